// File: rtl/x_mem_responder.sv
// Latency-programmable single-port word memory on the core's valid/accept bus.
// Optional out-of-range detection via `define X_MEM_RESPONDER_OOR_EN.
module x_mem_responder #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        i_clk,
    input  logic        i_nrst,
    input  logic        i_valid,
    input  logic        i_rnw,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_data,
    output logic        o_accept,
    output logic [31:0] o_data,
    output logic        o_err
);

    localparam int         AW      = $clog2(DEPTH);
    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            rnw_q, rnw_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            oor_q, oor_d;
    logic            err_q, err_d;
    logic            in_oor;
    logic            mem_we;
    logic [31:0]     mem [DEPTH];

`ifdef X_MEM_RESPONDER_OOR_EN
    assign in_oor = |i_addr[31:AW+2];
    logic unused_addr;
    assign unused_addr = ^i_addr[1:0];
`else
    assign in_oor = 1'b0;
    logic unused_addr;
    assign unused_addr = ^{i_addr[31:AW+2], i_addr[1:0]};
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rnw_d   = rnw_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        oor_d   = oor_q;
        rdata_d = rdata_q;
        err_d   = err_q;

        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    rnw_d   = i_rnw;
                    idx_d   = i_addr[AW+1:2];
                    wdata_d = i_data;
                    oor_d   = in_oor;
                    cnt_d   = WAIT_LD;
                    state_d = (WAIT_LD != 4'd0) ? WAIT : RESP;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Read data is captured on entry to RESP so it is valid alongside accept;
        // with zero wait this entry is straight from IDLE, hence the *_d fields.
        if (state_d == RESP) begin
            if (rnw_d) begin
                rdata_d = oor_d ? 32'hDEAD_BEEF : mem[idx_d];
            end
            if (oor_d) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rnw_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            oor_q   <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rnw_q   <= rnw_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            oor_q   <= oor_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Gated by reset so a write caught mid-RESP by reset is never committed.
    assign mem_we = (state_q == RESP) && !rnw_q && !oor_q && i_nrst;

    always_ff @(posedge i_clk) begin
        if (mem_we) begin
            mem[idx_q] <= wdata_q;
        end
    end

    assign o_accept = (state_q == RESP);
    assign o_data   = rdata_q;
    assign o_err    = err_q;

endmodule

// File: doc/x_mem_responder.md
Name: x_mem_responder

Overview:
- Single-port word memory that answers the core's valid/accept memory bus: instruction fetches, loads and stores.
- Sits between the rv32i core's memory interface and on-chip storage.
- Latches each request, waits a configurable number of cycles, then pulses accept with read data or commits the write.
- Gives the bench and SoC a deterministic, latency-programmable memory model in RTL.

Parameters:
- DEPTH, 1024: number of 32-bit words; power of two, minimum 16. AW = $clog2(DEPTH).
- WAIT_CYCLES, 0: extra wait cycles before accept; range 0..15.

Ports:
- i_clk  input  1  clock
- i_nrst  input  1  reset
- i_valid  input  1  request valid; requester holds it high until accept
- i_rnw  input  1  1 = read, 0 = write
- i_addr  input  32  byte address; bits [1:0] ignored
- i_data  input  32  write data
- o_accept  output  1  single-cycle completion pulse
- o_data  output  32  read data; valid in the o_accept cycle of a read
- o_err  output  1  sticky out-of-range flag; constant 0 without the optional feature

Interface decision: reset i_nrst, asynchronous, active-low; clock i_clk.

Behaviour:
- Reset values: o_accept=0, o_data=0, o_err=0, state=IDLE, wait counter=0.
- Memory array is not reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If i_valid=1, latch rnw, word index (i_addr[AW+1:2]) and data; load counter with WAIT_CYCLES.
  - Next state is WAIT if WAIT_CYCLES>0, else RESP.
  - If i_valid=0, stay in IDLE.
- WAIT:
  - Decrement counter each cycle.
  - Go to RESP when counter reaches 1 (counter is 4 bits).
- Entering RESP on a read: o_data register loads mem[index].
- RESP:
  - o_accept=1 (registered state decode).
  - Write: mem[index] <= latched data in this cycle.
  - Next state is always IDLE.
- Latency: request first seen in IDLE at cycle T gives o_accept at T+1+WAIT_CYCLES.
- o_data holds its last read value; writes never change it.
- Back-to-back requests:
  - The requester may keep i_valid high in the cycle after accept with a new request.
  - That request is sampled in the following IDLE cycle.
  - Maximum throughput is one transfer per 2+WAIT_CYCLES cycles.
  - i_valid seen during RESP is never treated as a new request.
- Read-after-write: a write commits in its RESP cycle, so the next read of the same address returns the new value.
- Protocol violation (i_valid drops during WAIT): the latched transaction still completes; accept pulses and the write commits.
- Request fields changing during WAIT: ignored; only values latched in IDLE are used.
- Reset mid-operation:
  - Immediate return to IDLE with o_accept=0.
  - A pending write in WAIT is discarded and memory is unchanged.
  - The RESP-cycle write is not committed if reset asserts in that cycle.
- Address decode: i_addr[31:AW+2] is ignored (aliasing) unless the optional feature is enabled.

Optional Feature:
- Macro: X_MEM_RESPONDER_OOR_EN.
- Defined:
  - A request with any nonzero i_addr[31:AW+2] is out-of-range.
  - A read returns 32'hDEADBEEF.
  - A write is dropped.
  - o_err sets on the accept cycle and stays set until reset.
  - Accept timing is unchanged.
- Undefined: upper address bits are ignored, addresses alias modulo 4*DEPTH, and o_err is tied to 0.

Test Plan:
- WAIT_CYCLES=0: write 0x100 = 0xCAFEF00D, then read 0x100 -> each accept exactly one cycle after valid is sampled; read o_data=0xCAFEF00D.
- WAIT_CYCLES=3: read held valid from cycle T -> o_accept only at T+4, single cycle; o_data valid in that cycle.
- Back-to-back: read 0x0 with valid kept high after accept and address switched to 0x4 -> second accept two cycles after the first; data from word 1; no duplicate accept for 0x0.
- Reset mid-WAIT (WAIT_CYCLES=5): write 0x20=0x12345678, reset asserted at cycle 2 of WAIT -> no accept; a later read of 0x20 returns the previous value.
- Byte offset: write 0x40=0xA5A5A5A5, read 0x43 -> 0xA5A5A5A5.
- Out-of-range, read 4*DEPTH:
  - With X_MEM_RESPONDER_OOR_EN: returns 0xDEADBEEF, o_err=1 and stays 1.
  - Without it: returns word 0 contents, o_err=0.
